// File: rtl/lsu_rmw_pkg.sv
// lsu_rmw_pkg: shared types and constants for the load/store unit.
//   addr_t / data_t / enable_t : common word, address and strobe types
//   lsu_state_e                : LSU controller states
//   F3_*                       : RV32I load/store funct3 encodings
//   f3_invalid()               : funct3 values that are not a load/store width
package lsu_rmw_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] data_t;
    typedef logic        enable_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WRITE,
        RESP
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic f3_invalid(input logic [2:0] f3);
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

endpackage

// File: rtl/lsu_rmw_align.sv
// lsu_align: combinational lane logic for the load/store unit.
//   funct3_i    : access width/sign (low two bits select B/H/W, bit 2 = unsigned)
//   addr_lo_i   : byte offset within the word
//   word_i      : word read from memory
//   wdata_i     : store data (low byte/half used for sub-word stores)
//   load_data_o : extracted and sign/zero-extended load value
//   merged_o    : word_i with the store byte/half inserted at its lane
// Width codes 2'b10 and 2'b11 both behave as a full word.
module lsu_align
    import lsu_rmw_pkg::*;
(
    input  logic [2:0] funct3_i,
    input  logic [1:0] addr_lo_i,
    input  data_t      word_i,
    input  data_t      wdata_i,
    output data_t      load_data_o,
    output data_t      merged_o
);

    logic [4:0]  byte_sh;
    logic [4:0]  half_sh;
    logic [7:0]  byte_val;
    logic [15:0] half_val;
    logic        sext;

    always_comb begin
        byte_sh     = {addr_lo_i, 3'b000};
        half_sh     = {addr_lo_i[1], 4'b0000};
        byte_val    = word_i[byte_sh +: 8];
        half_val    = word_i[half_sh +: 16];
        sext        = ~funct3_i[2];
        load_data_o = word_i;
        merged_o    = wdata_i;
        case (funct3_i[1:0])
            2'b00: begin
                load_data_o               = {{24{byte_val[7] & sext}}, byte_val};
                merged_o                  = word_i;
                merged_o[byte_sh +: 8]    = wdata_i[7:0];
            end
            2'b01: begin
                load_data_o               = {{16{half_val[15] & sext}}, half_val};
                merged_o                  = word_i;
                merged_o[half_sh +: 16]   = wdata_i[15:0];
            end
            default: begin
                load_data_o = word_i;
                merged_o    = wdata_i;
            end
        endcase
    end

endmodule

// File: rtl/lsu_rmw.sv
// lsu_rmw: load/store unit between the MEM stage and a word-wide memory port.
// Sub-word stores are done as read-modify-write (read in ACCESS, write in WRITE).
// Build option: define LSU_MISALIGN_CHECK_EN to enable misalignment / invalid
// funct3 detection with an error response; otherwise no check is made and
// resp_misaligned_o stays 0.
// Ports:
//   clk, rst_n             : clock, synchronous active-low reset
//   req_valid_i/req_ready_o: request handshake (ready only in IDLE)
//   req_we_i, req_funct3_i : store flag, RV32I width/sign encoding
//   req_addr_i, req_wdata_i: byte address, store data
//   resp_valid_o/resp_ready_i, resp_rdata_o, resp_misaligned_o : response beat
//   dmem_addr_o, dmem_ren_o, dmem_rdata_i, dmem_wen_o, dmem_wdata_o : memory port
module lsu_rmw
    import lsu_rmw_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter bit          STORE_RESP = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [2:0]        req_funct3_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [31:0]       resp_rdata_o,
    output logic              resp_misaligned_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic              dmem_ren_o,
    input  logic [31:0]       dmem_rdata_i,
    output logic              dmem_wen_o,
    output logic [31:0]       dmem_wdata_o
);

    lsu_state_e        state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        f3_q, f3_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    data_t             wdata_q, wdata_d;
    data_t             rdata_q, rdata_d;
    data_t             merged_q, merged_d;
    logic              mis_q, mis_d;

    logic              req_mis;
    logic              sub_word;
    enable_t           ren, wen;
    data_t             load_data, merged;

    lsu_align u_align (
        .funct3_i    (f3_q),
        .addr_lo_i   (addr_q[1:0]),
        .word_i      (dmem_rdata_i),
        .wdata_i     (wdata_q),
        .load_data_o (load_data),
        .merged_o    (merged)
    );

`ifdef LSU_MISALIGN_CHECK_EN
    always_comb begin
        req_mis = f3_invalid(req_funct3_i)
               || ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0])
               || ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));
    end
`else
    // Without the check mis_q can never be set, so resp_misaligned_o is constant 0.
    assign req_mis = 1'b0;
`endif

    // B/H/BU/HU have funct3[1] clear; everything else stores a full word.
    assign sub_word = ~f3_q[1];

    // Enables are qualified by rst_n so a write in flight when reset is
    // applied never reaches memory at the reset edge.
    assign dmem_ren_o = ren & rst_n;
    assign dmem_wen_o = wen & rst_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            f3_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            merged_q <= '0;
            mis_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            f3_q     <= f3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            merged_q <= merged_d;
            mis_q    <= mis_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        we_d              = we_q;
        f3_d              = f3_q;
        addr_d            = addr_q;
        wdata_d           = wdata_q;
        rdata_d           = rdata_q;
        merged_d          = merged_q;
        mis_d             = mis_q;
        req_ready_o       = 1'b0;
        resp_valid_o      = 1'b0;
        resp_rdata_o      = '0;
        resp_misaligned_o = 1'b0;
        dmem_addr_o       = '0;
        dmem_wdata_o      = '0;
        ren               = 1'b0;
        wen               = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    we_d    = req_we_i;
                    f3_d    = req_funct3_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    rdata_d = '0;
                    mis_d   = req_mis;
                    state_d = req_mis ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                dmem_addr_o = {addr_q[ADDR_W-1:2], 2'b00};
                if (!we_q) begin
                    ren     = 1'b1;
                    rdata_d = load_data;
                    state_d = RESP;
                end else if (sub_word) begin
                    ren      = 1'b1;
                    merged_d = merged;
                    state_d  = WRITE;
                end else begin
                    wen          = 1'b1;
                    dmem_wdata_o = wdata_q;
                    state_d      = STORE_RESP ? RESP : IDLE;
                end
            end
            WRITE: begin
                dmem_addr_o  = {addr_q[ADDR_W-1:2], 2'b00};
                wen          = 1'b1;
                dmem_wdata_o = merged_q;
                state_d      = STORE_RESP ? RESP : IDLE;
            end
            RESP: begin
                resp_valid_o      = 1'b1;
                resp_rdata_o      = rdata_q;
                resp_misaligned_o = mis_q;
                if (resp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_lsu_rmw.sv
// tb_lsu_rmw: scoreboard bench for lsu_rmw with a small word memory model.
// Honours LSU_MISALIGN_CHECK_EN the same way as the design.
module tb_lsu_rmw;
    import lsu_rmw_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_mis;
    logic [31:0] resp_rdata;
    logic [31:0] dmem_addr, dmem_rdata, dmem_wdata;
    logic        dmem_ren, dmem_wen;

    typedef struct { logic [31:0] rdata; logic mis; } resp_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
    resp_t exp_q[$];
    wr_t   wr_q[$];

    logic [31:0] mem [0:255];
    logic [31:0] exp_raddr;
    int          checks = 0;
    int          errors = 0;
    int          ren_cnt = 0;
    int          wen_cnt = 0;

    always #5 clk = ~clk;

    lsu_rmw #(.ADDR_W(32), .STORE_RESP(1'b1)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req_valid_i       (req_valid),
        .req_ready_o       (req_ready),
        .req_we_i          (req_we),
        .req_funct3_i      (req_funct3),
        .req_addr_i        (req_addr),
        .req_wdata_i       (req_wdata),
        .resp_valid_o      (resp_valid),
        .resp_ready_i      (resp_ready),
        .resp_rdata_o      (resp_rdata),
        .resp_misaligned_o (resp_mis),
        .dmem_addr_o       (dmem_addr),
        .dmem_ren_o        (dmem_ren),
        .dmem_rdata_i      (dmem_rdata),
        .dmem_wen_o        (dmem_wen),
        .dmem_wdata_o      (dmem_wdata)
    );

    assign dmem_rdata = mem[dmem_addr[9:2]];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h40] = 32'h8899AABB;
        mem[8'h41] = 32'h11223344;
        forever begin
            @(posedge clk);
            if (dmem_wen) mem[dmem_addr[9:2]] <= dmem_wdata;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: response beats against the scoreboard, memory port activity.
    initial begin
        resp_t e;
        wr_t   w;
        forever begin
            @(negedge clk);
            if (dmem_ren && dmem_wen) chk("ren_wen_exclusive", 32'd1, 32'd0);
            if (dmem_ren) begin
                ren_cnt++;
                chk("ren_addr", dmem_addr, exp_raddr);
            end
            if (dmem_wen) begin
                wen_cnt++;
                if (wr_q.size() == 0) begin
                    chk("unexpected_write", dmem_addr, 32'hFFFF_FFFF);
                end else begin
                    w = wr_q.pop_front();
                    chk("wr_addr", dmem_addr, w.addr);
                    chk("wr_data", dmem_wdata, w.data);
                end
            end
            if (resp_valid && resp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_resp", resp_rdata, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_rdata", resp_rdata, e.rdata);
                    chk("resp_mis", {31'b0, resp_mis}, {31'b0, e.mis});
                end
            end
        end
    end

    task automatic exp_write(input logic [31:0] addr, input logic [31:0] data);
        wr_t w;
        w.addr = addr;
        w.data = data;
        wr_q.push_back(w);
    endtask

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_mis,
                         input int exp_lat, input bit hold);
        resp_t e;
        int    lat;
        @(negedge clk);
        chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
        e.rdata = exp_rd;
        e.mis   = exp_mis;
        exp_q.push_back(e);
        exp_raddr  = {addr[31:2], 2'b00};
        resp_ready = !hold;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, exp_lat);
        if (hold) begin
            for (int k = 0; k < 5; k++) begin
                @(posedge clk); #1;
                chk("stall_valid", {31'b0, resp_valid}, 32'd1);
                chk("stall_rdata", resp_rdata, exp_rd);
                chk("stall_req_ready", {31'b0, req_ready}, 32'd0);
            end
            resp_ready = 1'b1;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int r0, w0;
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int r0, w0;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
        req_addr = '0; req_wdata = '0; resp_ready = 1'b1; exp_raddr = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_outputs", {dmem_ren, dmem_wen, resp_mis, 29'b0}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        rst_n = 1'b1;

        // Loads from 0x8899AABB at 0x100.
        issue(1'b0, F3_B,  32'h101, '0, 32'hFFFFFFAA, 1'b0, 2, 1'b0);
        issue(1'b0, F3_BU, 32'h103, '0, 32'h00000088, 1'b0, 2, 1'b0);
        issue(1'b0, F3_H,  32'h100, '0, 32'hFFFFAABB, 1'b0, 2, 1'b0);
        issue(1'b0, F3_HU, 32'h102, '0, 32'h00008899, 1'b0, 2, 1'b0);
        issue(1'b0, F3_W,  32'h100, '0, 32'h8899AABB, 1'b0, 2, 1'b0);

        // Sub-word stores (read-modify-write) and a full-word store.
        exp_write(32'h100, 32'h88CCAABB);
        issue(1'b1, F3_B, 32'h102, 32'h000000CC, 32'h0, 1'b0, 3, 1'b0);
        chk("mem_after_sb", mem[8'h40], 32'h88CCAABB);
        exp_write(32'h100, 32'h1234AABB);
        issue(1'b1, F3_H, 32'h102, 32'h00001234, 32'h0, 1'b0, 3, 1'b0);
        issue(1'b0, F3_H, 32'h102, '0, 32'h00001234, 1'b0, 2, 1'b0);
        issue(1'b0, F3_H, 32'h100, '0, 32'hFFFFAABB, 1'b0, 2, 1'b0);
        exp_write(32'h104, 32'hDEADBEEF);
        issue(1'b1, F3_W, 32'h104, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1'b0);
        exp_write(32'h104, 32'h80ADBEEF);
        issue(1'b1, F3_B, 32'h107, 32'hFFFFFF80, 32'h0, 1'b0, 3, 1'b0);
        exp_write(32'h104, 32'h80ADBE7F);
        issue(1'b1, F3_B, 32'h104, 32'h0000007F, 32'h0, 1'b0, 3, 1'b0);
        issue(1'b0, F3_B,  32'h107, '0, 32'hFFFFFF80, 1'b0, 2, 1'b0);
        issue(1'b0, F3_BU, 32'h104, '0, 32'h0000007F, 1'b0, 2, 1'b0);
        issue(1'b0, F3_HU, 32'h106, '0, 32'h000080AD, 1'b0, 2, 1'b0);

`ifdef LSU_MISALIGN_CHECK_EN
        r0 = ren_cnt;
        w0 = wen_cnt;
        issue(1'b0, F3_W,   32'h102, '0, 32'h0, 1'b1, 1, 1'b0);
        issue(1'b0, F3_H,   32'h101, '0, 32'h0, 1'b1, 1, 1'b0);
        issue(1'b0, 3'b011, 32'h100, '0, 32'h0, 1'b1, 1, 1'b0);
        issue(1'b1, F3_H,   32'h101, 32'h0000FFFF, 32'h0, 1'b1, 1, 1'b0);
        chk("mis_no_ren", ren_cnt, r0);
        chk("mis_no_wen", wen_cnt, w0);
        chk("mis_mem_unchanged", mem[8'h40], 32'h1234AABB);
`else
        issue(1'b0, F3_W,   32'h102, '0, 32'h1234AABB, 1'b0, 2, 1'b0);
        issue(1'b0, F3_H,   32'h101, '0, 32'hFFFFAABB, 1'b0, 2, 1'b0);
        issue(1'b0, 3'b011, 32'h100, '0, 32'h1234AABB, 1'b0, 2, 1'b0);
`endif

        // Response held off for five cycles.
        issue(1'b0, F3_W, 32'h104, '0, 32'h80ADBE7F, 1'b0, 2, 1'b1);

        // Reset while an SB is in its WRITE cycle; the write must not land.
        @(negedge clk);
        exp_raddr = 32'h100;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_B;
        req_addr = 32'h100; req_wdata = 32'h00000055;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rst_write_wen_gated", {31'b0, dmem_wen}, 32'd0);
        @(posedge clk); #1;
        chk("rst_write_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_write_wen", {31'b0, dmem_wen}, 32'd0);
        chk("rst_write_resp_valid", {31'b0, resp_valid}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_write_mem", mem[8'h40], 32'h1234AABB);

        issue(1'b0, F3_W, 32'h100, '0, 32'h1234AABB, 1'b0, 2, 1'b0);

        repeat (3) @(posedge clk);
        chk("resp_queue_empty", exp_q.size(), 32'd0);
        chk("write_queue_empty", wr_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
